dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder (slave) for the pipeline's MEM-stage load/store port.
//  Accepts one request at a time over a valid/ready handshake and applies RV32 funct3 width semantics:
//   - loads LB/LH/LW/LBU/LHU with sign/zero extension
//   - stores SB/SH/SW with byte-lane merge
//  Inserts a configurable number of wait states and returns data/error on a valid/ready response channel.
//  The core stalls MEM while req_ready or rsp_valid is low.
// PARAMETERS
//  DEPTH_WORDS  1024       number of 32-bit words in the array (power of 2)
//  WAIT_STATES  1          extra cycles between accept and response, 0..15
//  ADDR_BASE    32'h0      byte address mapped to word 0
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   reset, asynchronous, active-high
//  req_valid  in   1   request present
//  req_ready  out  1   responder can accept (IDLE only)
//  req_we     in   1   1=store, 0=load
//  req_funct3 in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data, right-aligned (rs2)
//  rsp_valid  out  1   response present; held until rsp_ready
//  rsp_ready  in   1   core consumes response
//  rsp_rdata  out  32  load result after extension; 0 for stores and errors
//  rsp_err    out  1   access fault (range / misalign / bad funct3)
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, state=IDLE.
//  Array contents are not reset.
//  FSM states and transitions:
//   - IDLE -> (req_valid & req_ready) -> WAIT, or RESP if WAIT_STATES==0.
//   - WAIT: down-counter loaded with WAIT_STATES-1; -> RESP when the count reaches 0.
//   - RESP: rsp_valid=1, outputs stable; -> IDLE on rsp_ready.
//  Accept: on accept, latch we/funct3/addr/wdata. Inputs may change afterwards with no effect.
//  Latency: rsp_valid is first high in the cycle after edge (accept edge + WAIT_STATES).
//   - Back-to-back throughput: one request per WAIT_STATES+2 cycles.
//   - req_ready is low in WAIT and RESP. It rises the cycle after the rsp_ready handshake, so there is no same-cycle re-accept.
//  Array access: read or write happens exactly once, on the edge entering RESP.
//  Address: off = addr - ADDR_BASE, unsigned 32-bit wrap.
//   - off >= DEPTH_WORDS*4 -> rsp_err=1, no write, rdata=0.
//   - Word index = off[log2(DEPTH_WORDS*4)-1:2]; lane = off[1:0].
//  Loads:
//   - B/BU select byte[lane], H/HU select half[lane[1]].
//   - Signed forms sign-extend from bit 7 or bit 15; unsigned forms zero-extend.
//  Stores:
//   - SB writes byte[lane] = wdata[7:0]; SH writes half[lane[1]] = wdata[15:0]; SW writes the full word.
//   - Other bytes are untouched.
//  funct3 011/110/111, or 1xx with we=1: rsp_err=1, no write.
//  Reset mid-operation (WAIT or RESP): return to IDLE and drop the response.
//   - A store not yet committed (still in WAIT) is discarded.
//   - A store already committed stays in the array.
//  rsp_ready while not in RESP: ignored.
// CONFIGURATION
//  DMEM_MISALIGN_ERR_EN
//   - Defined: H with lane[0]!=0, or W with lane!=0 -> rsp_err=1, no write, rdata=0.
//   - Undefined: low address bits are forced to alignment (H ignores bit 0, W ignores bits 1:0) and no error is raised.
//   - rsp_err still reports range and funct3 faults in both builds.
// TESTING
//  1. WAIT_STATES=1. SW addr 0x10, wdata 0xDEADBEEF, then LW 0x10.
//     -> Each rsp_valid is high 2 cycles after accept; LW rdata=0xDEADBEEF, err=0.
//  2. Word 0x20 holds 0x80FF7F01.
//     -> LB 0x23 = 0xFFFFFF80; LBU 0x23 = 0x00000080; LH 0x22 = 0xFFFF80FF; LHU 0x20 = 0x00007F01.
//  3. Word 0x40 holds 0x11223344. SB 0x41 wdata 0xAA, then SH 0x42 wdata 0xBEEF.
//     -> LW 0x40 = 0xBEEFAA44.
//  4. DEPTH_WORDS=1024: LW 0x1000 -> err=1, rdata=0. SW 0x1000 -> err=1, and no word in the array changes.
//  5. Hold rsp_ready=0 for 5 cycles in RESP.
//     -> rsp_valid/rdata stable and req_ready=0 throughout; req_ready=1 the cycle after rsp_ready.
//  6. With DMEM_MISALIGN_ERR_EN: LW 0x12 -> err=1. Without it: LW 0x12 returns word 0x10.
//     Also: assert rst while a SW 0x50 is in WAIT -> word 0x50 unchanged, rsp_valid=0.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store port: valid/ready request and response
// channels, RV32 width semantics, and WAIT_STATES wait states. Optional macro: DMEM_MISALIGN_ERR_EN.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ADDR_BASE   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        enter_resp;
  logic        op_we;
  logic [2:0]  op_f3;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic [31:0] off;
  logic [AW-1:0] idx;
  logic [1:0]  lane;
  logic [31:0] word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        in_range;
  logic        bad_f3;
  logic        misalign;
  logic        fault;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic        wr_en;

  assign accept     = (state == S_IDLE) && req_valid && req_ready;
  assign enter_resp = (accept && (WAIT_STATES == 0)) || ((state == S_WAIT) && (cnt == 4'd0));

  // With zero wait states the access happens on the accept edge, so decode the live request.
  assign op_we    = (state == S_IDLE) ? req_we     : we_q;
  assign op_f3    = (state == S_IDLE) ? req_funct3 : f3_q;
  assign op_addr  = (state == S_IDLE) ? req_addr   : addr_q;
  assign op_wdata = (state == S_IDLE) ? req_wdata  : wdata_q;

  assign off      = op_addr - ADDR_BASE;
  assign idx      = off[AW+1:2];
  assign lane     = off[1:0];
  assign word     = mem[idx];
  assign byte_sel = word[{lane, 3'b000} +: 8];
  assign half_sel = word[{lane[1], 4'b0000} +: 16];
  assign in_range = ({1'b0, off} < SPAN);
  assign bad_f3   = (op_f3 == 3'b011) || (op_f3[2] && (op_f3[1:0] == 2'b10 || op_f3[1:0] == 2'b11))
                    || (op_we && op_f3[2]);

`ifdef DMEM_MISALIGN_ERR_EN
  assign misalign = ((op_f3[1:0] == 2'b01) && lane[0]) || ((op_f3[1:0] == 2'b10) && (lane != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign fault = !in_range || bad_f3 || misalign;
  assign wr_en = enter_resp && op_we && !fault && !rst;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    load_data = '0;
    merged    = word;
    case (op_f3)
      3'b000: begin
        load_data = {{24{byte_sel[7]}}, byte_sel};
        merged[{lane, 3'b000} +: 8] = op_wdata[7:0];
      end
      3'b001: begin
        load_data = {{16{half_sel[15]}}, half_sel};
        merged[{lane[1], 4'b0000} +: 16] = op_wdata[15:0];
      end
      3'b010: begin
        load_data = word;
        merged    = op_wdata;
      end
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = '0;
    endcase
  end

  // NOTE: the storage array has no reset; only control state is reset, so contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= merged;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            we_q      <= req_we;
            f3_q      <= req_funct3;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= S_WAIT;
            cnt       <= WAIT_LOAD;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
      // The single array access and the response capture share this edge.
      if (enter_resp) begin
        state     <= S_RESP;
        rsp_valid <= 1'b1;
        rsp_err   <= fault;
        rsp_rdata <= (fault || op_we) ? 32'd0 : load_data;
      end
    end
  end

endmodule
